cpu_trace_buffer: RTL and testbench

- Parametrised instruction-trace capture block for the cpu6502 core.
- Records one snapshot per opcode fetch: {PC, A, X, Y, SR, SP}.
- Holds a circular pre-trigger history, then a fixed post-trigger window, and streams the frozen trace out over a valid/ready port.
- Sits beside cpu6502_top so traces come from hardware runs instead of only from simulation probes.

---
 rtl/cpu_trace_buffer.sv | 178 +++++++++++++++++
 tb/tb_cpu_trace_buffer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_trace_buffer.sv
`default_nettype none
// ============================================================================
// Module      : cpu_trace_buffer
// Description : Instruction-trace capture for the cpu6502 core. Records one
//               {PC, A, X, Y, SR, SP} snapshot per opcode fetch into a
//               circular history, freezes it a fixed number of entries after
//               a trigger, then streams the trace oldest-first over a
//               valid/ready port.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_trace_buffer #(
  parameter  int DEPTH   = 32,
  parameter  int ADDR_W  = 16,
  parameter  int DATA_W  = 8,
  parameter  int POST    = 16,
  localparam int ENTRY_W = ADDR_W + 5*DATA_W,
  localparam int CW      = $clog2(DEPTH) + 1
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               arm,
  input  logic               abort,
  input  logic               sync,
  input  logic [ADDR_W-1:0]  pc,
  input  logic [DATA_W-1:0]  a,
  input  logic [DATA_W-1:0]  x,
  input  logic [DATA_W-1:0]  y,
  input  logic [DATA_W-1:0]  sr,
  input  logic [DATA_W-1:0]  sp,
  input  logic [ADDR_W-1:0]  trig_pc,
  input  logic [ADDR_W-1:0]  trig_mask,
  input  logic               ext_trig,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ENTRY_W-1:0] out_data,
  output logic               out_last,
  output logic [1:0]         state_o,
  output logic [CW-1:0]      count,
  output logic               overflow
);

  localparam int            AW      = $clog2(DEPTH);
  localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);
  localparam logic [CW-1:0] C_POST  = CW'(POST);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_POST  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]       count_q, count_d;
  logic [CW-1:0]       post_cnt_q, post_cnt_d;
  logic [CW-1:0]       remaining_q, remaining_d;
  logic                overflow_q, overflow_d;
  logic                w_wr_en;
  logic                w_match;
  logic                w_trig;
  logic [CW-1:0]       w_count_inc;
  logic [ENTRY_W-1:0]  mem_q [DEPTH];

  // Snapshot packing: PC occupies the MSBs, SP the LSBs.
  logic [ENTRY_W-1:0] w_entry;
  assign w_entry     = {pc, a, x, y, sr, sp};
  assign w_match     = sync && (((pc ^ trig_pc) & trig_mask) == '0);
  assign w_trig      = w_match || ext_trig;
  assign w_count_inc = (count_q == C_DEPTH) ? C_DEPTH : count_q + CW'(1);

  // Next-state logic: abort beats arm, arm beats capture/trigger.
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    post_cnt_d  = post_cnt_q;
    remaining_d = remaining_q;
    overflow_d  = overflow_q;
    w_wr_en     = 1'b0;

    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (arm) begin
            state_d    = S_ARMED;
            wr_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
          end
        end
        S_ARMED: begin
          if (sync) begin
            w_wr_en  = 1'b1;
            wr_ptr_d = wr_ptr_q + AW'(1);
            count_d  = w_count_inc;
            if (count_q == C_DEPTH) overflow_d = 1'b1;
            if (w_trig) begin
              post_cnt_d = C_POST - CW'(1);
              state_d    = (POST == 1) ? S_DONE : S_POST;
            end
          end else if (ext_trig) begin
            post_cnt_d = C_POST;
            state_d    = S_POST;
          end
        end
        S_POST: begin
          if (sync) begin
            w_wr_en    = 1'b1;
            wr_ptr_d   = wr_ptr_q + AW'(1);
            count_d    = w_count_inc;
            post_cnt_d = post_cnt_q - CW'(1);
            if (count_q == C_DEPTH) overflow_d = 1'b1;
            if (post_cnt_q == CW'(1)) state_d = S_DONE;
          end
        end
        default: begin
          if (arm) begin
            state_d    = S_ARMED;
            wr_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
          end else if (out_valid && out_ready) begin
            rd_ptr_d    = rd_ptr_q + AW'(1);
            remaining_d = remaining_q - CW'(1);
          end
        end
      endcase
    end

    // Entering DONE: point at the oldest surviving entry. A full buffer has
    // count low bits of zero, so the oldest entry is the one at wr_ptr.
    if (state_d == S_DONE && state_q != S_DONE) begin
      rd_ptr_d    = wr_ptr_d - count_d[AW-1:0];
      remaining_d = count_d;
    end
  end

  // Control state register with asynchronous clear.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      post_cnt_q  <= '0;
      remaining_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      post_cnt_q  <= post_cnt_d;
      remaining_q <= remaining_d;
      overflow_q  <= overflow_d;
    end
  end

  // Trace storage; contents are don't-care after reset.
  always_ff @(posedge CLK) begin
    if (w_wr_en) mem_q[wr_ptr_q] <= w_entry;
  end

  // Readout is combinational from the frozen buffer so it drops with reset.
  assign out_valid = (state_q == S_DONE) && (remaining_q != '0);
  assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
  assign out_last  = out_valid && (remaining_q == CW'(1));
  assign state_o   = state_q;
  assign count     = count_q;
  assign overflow  = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_cpu_trace_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_trace_buffer
// Description : Directed plus randomized bench for cpu_trace_buffer with a
//               queue-based trace model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_trace_buffer;

  localparam int DEPTH   = 8;
  localparam int POST    = 4;
  localparam int ADDR_W  = 16;
  localparam int DATA_W  = 8;
  localparam int ENTRY_W = ADDR_W + 5*DATA_W;
  localparam int CW      = $clog2(DEPTH) + 1;

  logic               CLK = 1'b0;
  logic               RESET;
  logic               arm, abort, sync, ext_trig, out_ready;
  logic [ADDR_W-1:0]  pc, trig_pc, trig_mask;
  logic [DATA_W-1:0]  a, x, y, sr, sp;
  logic               out_valid, out_last, overflow;
  logic [ENTRY_W-1:0] out_data;
  logic [1:0]         state_o;
  logic [CW-1:0]      count;

  cpu_trace_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .POST(POST)) dut (
    .CLK(CLK), .RESET(RESET), .arm(arm), .abort(abort), .sync(sync), .pc(pc),
    .a(a), .x(x), .y(y), .sr(sr), .sp(sp), .trig_pc(trig_pc), .trig_mask(trig_mask),
    .ext_trig(ext_trig), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .state_o(state_o), .count(count),
    .overflow(overflow)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int passes = 0;

  // Reference model: every entry since arm kept in a queue trimmed to DEPTH.
  int                 m_mode;
  logic [ENTRY_W-1:0] m_hist[$];
  logic [ENTRY_W-1:0] m_out[$];
  int                 m_rd;
  bit                 m_ovf;
  int                 m_left;
  logic [ADDR_W-1:0]  got[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) begin
      passes++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_hist.delete(); m_out.delete(); m_rd = 0; m_ovf = 0; m_left = 0;
  endtask

  task automatic model_push(input logic [ENTRY_W-1:0] e);
    m_hist.push_back(e);
    if (m_hist.size() > DEPTH) begin
      void'(m_hist.pop_front());
      m_ovf = 1;
    end
  endtask

  task automatic model_done();
    m_mode = 3; m_out = m_hist; m_rd = 0;
  endtask

  task automatic model_step();
    logic [ENTRY_W-1:0] e;
    bit match, vnow;
    e     = {pc, a, x, y, sr, sp};
    match = sync && (((pc ^ trig_pc) & trig_mask) == 16'h0);
    vnow  = (m_mode == 3) && (m_rd < m_out.size());
    if (abort) m_mode = 0;
    else if ((m_mode == 0 || m_mode == 3) && arm) begin
      m_mode = 1; m_hist.delete(); m_ovf = 0;
    end else if (m_mode == 1) begin
      if (sync) begin
        model_push(e);
        if (match || ext_trig) begin
          m_left = POST - 1;
          if (m_left == 0) model_done(); else m_mode = 2;
        end
      end else if (ext_trig) begin
        m_left = POST; m_mode = 2;
      end
    end else if (m_mode == 2) begin
      if (sync) begin
        model_push(e);
        m_left--;
        if (m_left == 0) model_done();
      end
    end else if (m_mode == 3) begin
      if (vnow && out_ready) m_rd++;
    end
  endtask

  task automatic check_all();
    bit ev;
    ev = (m_mode == 3) && (m_rd < m_out.size());
    check("state", 64'(state_o), 64'(m_mode));
    check("count", 64'(count), 64'(m_hist.size()));
    check("overflow", 64'(overflow), 64'(m_ovf));
    check("out_valid", 64'(out_valid), 64'(ev));
    check("out_last", 64'(out_last), 64'(ev && (m_rd == m_out.size() - 1)));
    if (ev) check("out_data", 64'(out_data), 64'(m_out[m_rd]));
  endtask

  // One clock with the given inputs; register fields are random each cycle.
  task automatic cyc(input bit i_arm, input bit i_abort, input bit i_sync,
                     input logic [ADDR_W-1:0] i_pc, input bit i_ext, input bit i_ready);
    arm = i_arm; abort = i_abort; sync = i_sync; pc = i_pc;
    ext_trig = i_ext; out_ready = i_ready;
    a = 8'($urandom); x = 8'($urandom); y = 8'($urandom);
    sr = 8'($urandom); sp = 8'($urandom);
    model_step();
    if (out_valid && out_ready) got.push_back(out_data[ENTRY_W-1 -: ADDR_W]);
    @(posedge CLK); #1;
    check_all();
  endtask

  task automatic check_order(input string tag, input logic [ADDR_W-1:0] exp[$]);
    check({tag, "_len"}, 64'(got.size()), 64'(exp.size()));
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      check(tag, 64'(got[i]), 64'(exp[i]));
  endtask

  initial begin
    logic [ADDR_W-1:0] exp_q[$];
    RESET = 1'b1; arm = 0; abort = 0; sync = 0; pc = '0; ext_trig = 0; out_ready = 0;
    a = 0; x = 0; y = 0; sr = 0; sp = 0; trig_pc = 16'hC000; trig_mask = 16'hFFFF;
    model_reset();
    repeat (2) @(posedge CLK);
    #1; RESET = 1'b0;
    check_all();

    // 1: syncs without arm are not captured
    cyc(0, 0, 1, 16'h1234, 0, 0);
    cyc(0, 0, 1, 16'h1235, 0, 0);
    check("idle_count", 64'(count), 64'd0);

    // 2: basic trigger mid-stream; sync in the arm cycle is dropped
    trig_pc = 16'hC000;
    cyc(1, 0, 1, 16'h7777, 0, 0);
    exp_q = '{16'h8000, 16'h8001, 16'h8002, 16'hC000, 16'h8003, 16'h8004, 16'h8005};
    foreach (exp_q[i]) cyc(0, 0, 1, exp_q[i], 0, 0);
    check("t2_state", 64'(state_o), 64'd3);
    check("t2_count", 64'(count), 64'd7);
    got.delete();
    repeat (9) cyc(0, 0, 0, 16'h0, 0, 1);
    check_order("t2_order", exp_q);

    // 3: wrap and overflow
    trig_pc = 16'h00FF;
    cyc(1, 0, 0, 16'h0, 0, 0);
    for (int i = 0; i < 10; i++) cyc(0, 0, 1, 16'(i), 0, 0);
    cyc(0, 0, 1, 16'h00FF, 0, 0);
    cyc(0, 0, 1, 16'h0100, 0, 0);
    cyc(0, 0, 1, 16'h0101, 0, 0);
    cyc(0, 0, 1, 16'h0102, 0, 0);
    check("t3_count", 64'(count), 64'd8);
    check("t3_overflow", 64'(overflow), 64'd1);
    got.delete();
    repeat (10) cyc(0, 0, 0, 16'h0, 0, 1);
    exp_q = '{16'h6, 16'h7, 16'h8, 16'h9, 16'h00FF, 16'h0100, 16'h0101, 16'h0102};
    check_order("t3_order", exp_q);

    // 4: backpressure then alternating ready (arm from DONE restarts)
    trig_pc = 16'h1000;
    cyc(1, 0, 0, 16'h0, 0, 0);
    cyc(0, 0, 1, 16'h2000, 0, 0);
    cyc(0, 0, 0, 16'h0, 0, 0);
    cyc(0, 0, 1, 16'h2001, 0, 0);
    cyc(0, 0, 1, 16'h1000, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 16'h3000 + 16'(i), 0, 0);
    got.delete();
    repeat (3) cyc(0, 0, 0, 16'h0, 0, 0);
    for (int i = 0; i < 16; i++) cyc(0, 0, 0, 16'h0, 0, i[0]);
    check("t4_delivered", 64'(got.size()), 64'd6);

    // 5a: masked compare on the high byte
    trig_mask = 16'hFF00; trig_pc = 16'hC000;
    cyc(1, 0, 0, 16'h0, 0, 0);
    cyc(0, 0, 1, 16'h1234, 0, 0);
    cyc(0, 0, 1, 16'hC0AB, 0, 0);
    check("t5a_post", 64'(state_o), 64'd2);
    repeat (3) cyc(0, 0, 1, 16'h4000, 0, 0);
    check("t5a_done", 64'(state_o), 64'd3);

    // 5b: external trigger with no sync captures the next POST syncs
    trig_mask = 16'hFFFF;
    cyc(1, 0, 0, 16'h0, 0, 0);
    cyc(0, 0, 1, 16'h1111, 0, 0);
    cyc(0, 0, 0, 16'h0, 1, 0);
    cyc(0, 0, 1, 16'hC000, 0, 0);
    cyc(0, 0, 0, 16'h0, 0, 0);
    repeat (2) cyc(0, 0, 1, 16'h5000, 0, 0);
    check("t5b_not_done", 64'(state_o), 64'd2);
    cyc(0, 0, 1, 16'h5001, 0, 0);
    check("t5b_done", 64'(state_o), 64'd3);

    // 6: abort in POST, arm+abort together, async reset mid-readout
    cyc(1, 0, 0, 16'h0, 0, 0);
    cyc(0, 0, 0, 16'h0, 1, 0);
    cyc(0, 0, 1, 16'h6000, 0, 0);
    cyc(0, 1, 1, 16'h6001, 0, 0);
    check("t6_abort", 64'(state_o), 64'd0);
    cyc(1, 1, 0, 16'h0, 0, 0);
    check("t6_arm_abort", 64'(state_o), 64'd0);
    cyc(1, 0, 0, 16'h0, 0, 0);
    cyc(0, 0, 1, 16'hC000, 0, 0);
    repeat (3) cyc(0, 0, 1, 16'h7000, 0, 0);
    cyc(0, 0, 0, 16'h0, 0, 1);
    RESET = 1'b1;
    #1;
    check("t6_rst_valid", 64'(out_valid), 64'd0);
    check("t6_rst_state", 64'(state_o), 64'd0);
    check("t6_rst_count", 64'(count), 64'd0);
    model_reset();
    #1; RESET = 1'b0;
    cyc(0, 0, 0, 16'h0, 0, 0);

    // Randomized traffic against the model
    for (int blk = 0; blk < 6; blk++) begin
      trig_pc   = 16'hC000 + 16'(blk);
      trig_mask = (blk % 3 == 0) ? 16'hFFFF : (blk % 3 == 1) ? 16'hFF00 : 16'hFFF0;
      for (int i = 0; i < 80; i++) begin
        logic [ADDR_W-1:0] rpc;
        rpc = ($urandom_range(0, 5) == 0) ? trig_pc + 16'($urandom_range(0, 3))
                                          : 16'($urandom);
        cyc($urandom_range(0, 19) == 0, $urandom_range(0, 39) == 0,
            $urandom_range(0, 1) == 1, rpc, $urandom_range(0, 29) == 0,
            $urandom_range(0, 1) == 1);
      end
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
